// File: rtl/seq_gen_pkg.sv
// Shared types and default sizing for the serial pattern generator.
package seq_gen_pkg;

    localparam int DEF_W  = 16;
    localparam int DEF_RW = 8;
    localparam int DEF_GW = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/seq_gen_piso.sv
// W-bit parallel-in/serial-out shift register; the serial tap sits at bit len-1
// so that a pattern shorter than W still leaves its MSB first.
module seq_gen_piso
    import seq_gen_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int LW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          areset,
    input  logic          load,
    input  logic          shift,
    input  logic [W-1:0]  din,
    input  logic [LW-1:0] len,
    output logic          dout
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = din;
        end else if (shift) begin
            sr_d = {sr_q[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    // len of zero has no window; the tap simply reads as zero
    always_comb begin
        dout = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (int'(len) == i + 1) begin
                dout = sr_q[i];
            end
        end
    end

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial test-pattern transmitter: shifts a captured pattern out MSB-first,
// optionally repeating it with idle gaps, under a start/busy/done handshake.
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int LW = $clog2(W + 1),
    parameter int RW = DEF_RW,
    parameter int GW = DEF_GW
) (
    input  logic          clk,
    input  logic          areset,
    input  logic          start,
    input  logic [W-1:0]  pattern,
    input  logic [LW-1:0] len,
    input  logic [RW-1:0] repeat_n,
    input  logic [GW-1:0] gap,
    input  logic          stop,
    output logic          x,
    output logic          x_valid,
    output logic          busy,
    output logic          done
);

    localparam logic [LW-1:0] W_LEN = LW'(W);

    state_e        state_q, state_d;
    logic [W-1:0]  pat_q, pat_d;
    logic [LW-1:0] len_q, len_d;
    logic [RW-1:0] rep_n_q, rep_n_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [LW-1:0] bit_cnt_q, bit_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          stop_pend_q, stop_pend_d;
    logic          x_q, x_d;
    logic          x_valid_q, x_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [LW-1:0] len_sat;
    logic          piso_load;
    logic          piso_shift;
    logic [W-1:0]  piso_din;
    logic          piso_bit;
    logic          stop_now;
    logic          last_rep;

    seq_gen_piso #(
        .W  (W),
        .LW (LW)
    ) u_piso (
        .clk    (clk),
        .areset (areset),
        .load   (piso_load),
        .shift  (piso_shift),
        .din    (piso_din),
        .len    ((state_q == ST_IDLE) ? len_sat : len_q),
        .dout   (piso_bit)
    );

    always_comb begin
        len_sat = (len > W_LEN) ? W_LEN : len;
    end

    // A stop seen on the deciding cycle counts as pending, so a stop on the
    // final bit still ends the burst after that pattern.
    always_comb begin
        stop_now = stop_pend_q | stop;
        last_rep = (rep_n_q != '0) && (rep_cnt_q == rep_n_q - RW'(1));
    end

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        len_d       = len_q;
        rep_n_d     = rep_n_q;
        gap_d       = gap_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        stop_pend_d = stop_pend_q;
        piso_load   = 1'b0;
        piso_din    = pat_q;
        piso_shift  = (state_q == ST_SHIFT) && (bit_cnt_q != '0);

        case (state_q)
            ST_IDLE: begin
                stop_pend_d = 1'b0;
                // done_q still high means the previous burst just ended
                if (start && !done_q) begin
                    if (len_sat == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        pat_d     = pattern;
                        len_d     = len_sat;
                        rep_n_d   = repeat_n;
                        gap_d     = gap;
                        bit_cnt_d = len_sat - LW'(1);
                        rep_cnt_d = '0;
                        piso_load = 1'b1;
                        piso_din  = pattern;
                        state_d   = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (bit_cnt_q != '0) begin
                    bit_cnt_d = bit_cnt_q - LW'(1);
                end else if (last_rep || stop_now) begin
                    state_d = ST_DONE;
                end else begin
                    rep_cnt_d = rep_cnt_q + RW'(1);
                    piso_load = 1'b1;
                    bit_cnt_d = len_q - LW'(1);
                    if (gap_q != '0) begin
                        gap_cnt_d = gap_q - GW'(1);
                        state_d   = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (stop_now) begin
                    state_d = ST_DONE;
                end else if (gap_cnt_q == '0) begin
                    state_d = ST_SHIFT;
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            ST_DONE: begin
                stop_pend_d = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are a registered image of the current state, hence the
    // one-cycle lag between accepting start and the first bit.
    always_comb begin
        x_d       = (state_q == ST_SHIFT) && piso_bit;
        x_valid_d = (state_q == ST_SHIFT);
        busy_d    = (state_q == ST_SHIFT) || (state_q == ST_GAP);
        done_d    = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            rep_n_q     <= '0;
            gap_q       <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            rep_cnt_q   <= '0;
            stop_pend_q <= 1'b0;
            x_q         <= 1'b0;
            x_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            rep_n_q     <= rep_n_d;
            gap_q       <= gap_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            stop_pend_q <= stop_pend_d;
            x_q         <= x_d;
            x_valid_q   <= x_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: directed scenarios plus random
// bursts compared cycle by cycle against an expected serial stream.
module tb_seq_pattern_gen;

    localparam int W  = 16;
    localparam int LW = $clog2(W + 1);
    localparam int RW = 8;
    localparam int GW = 4;

    logic          clk = 1'b0;
    logic          areset = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  pattern = '0;
    logic [LW-1:0] len = '0;
    logic [RW-1:0] repeat_n = '0;
    logic [GW-1:0] gap = '0;
    logic          stop = 1'b0;
    logic          x;
    logic          x_valid;
    logic          busy;
    logic          done;

    int checks = 0;
    int passes = 0;

    seq_pattern_gen #(
        .W  (W),
        .LW (LW),
        .RW (RW),
        .GW (GW)
    ) dut (
        .clk      (clk),
        .areset   (areset),
        .start    (start),
        .pattern  (pattern),
        .len      (len),
        .repeat_n (repeat_n),
        .gap      (gap),
        .stop     (stop),
        .x        (x),
        .x_valid  (x_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Called on a falling edge; start is sampled at the following rising edge.
    task automatic applyStimulus(input logic [W-1:0] p, input int l, input int r, input int g);
        pattern  = p;
        len      = LW'(l);
        repeat_n = RW'(r);
        gap      = GW'(g);
        start    = 1'b1;
    endtask

    // Expected stream: each repetition sends bits len-1..0, gaps of zeros between.
    // stop_rep/stop_bit name the visible bit during which stop is pulsed (-1: none).
    task automatic runBurst(input logic [W-1:0] p, input int l, input int r, input int g,
                            input int stop_rep, input int stop_bit, input bit poke_start);
        bit [1:0] exp_q[$];
        int eff_len;
        int reps;
        int stop_idx;
        eff_len  = (l > W) ? W : l;
        reps     = r;
        if (stop_rep >= 0 && (r == 0 || stop_rep < r)) reps = stop_rep + 1;
        if (eff_len == 0) reps = 0;
        stop_idx = (stop_rep >= 0) ? stop_rep * (eff_len + g) + stop_bit : -1;
        for (int rep = 0; rep < reps; rep++) begin
            if (rep > 0) begin
                for (int k = 0; k < g; k++) exp_q.push_back(2'b00);
            end
            for (int b = eff_len - 1; b >= 0; b--) exp_q.push_back({1'b1, p[b]});
        end

        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        pattern  = W'($urandom);
        len      = LW'($urandom);
        repeat_n = RW'($urandom);
        gap      = GW'($urandom);
        checkOutput("busy_latency", 32'(busy), 32'd0);

        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("x_valid[%0d]", i), 32'(x_valid), 32'(exp_q[i][1]));
            checkOutput($sformatf("x[%0d]", i), 32'(x), 32'(exp_q[i][0]));
            checkOutput($sformatf("busy[%0d]", i), 32'(busy), 32'd1);
            checkOutput($sformatf("done_early[%0d]", i), 32'(done), 32'd0);
            stop = (i == stop_idx);
            if (poke_start && i == 1) begin
                pattern = 16'hFFFF;
                len     = LW'(4);
                start   = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        stop  = 1'b0;
        start = 1'b0;

        @(posedge clk);
        @(negedge clk);
        checkOutput("done_pulse", 32'(done), 32'd1);
        checkOutput("busy_at_done", 32'(busy), 32'd0);
        checkOutput("x_valid_at_done", 32'(x_valid), 32'd0);
        checkOutput("x_at_done", 32'(x), 32'd0);
    endtask

    task automatic idleCycle();
        @(posedge clk);
        @(negedge clk);
        checkOutput("done_single", 32'(done), 32'd0);
        checkOutput("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [W-1:0] p;
        int l;
        int r;
        int g;
        int eff;
        int srep;
        int sbit;

        #1 areset = 1'b1;
        #1;
        checkOutput("rst_x", 32'(x), 32'd0);
        checkOutput("rst_x_valid", 32'(x_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        areset = 1'b0;
        @(negedge clk);

        applyStimulus(16'b101, 3, 1, 0);
        runBurst(16'b101, 3, 1, 0, -1, 0, 1'b0);
        idleCycle();

        applyStimulus(16'b101, 3, 2, 2);
        runBurst(16'b101, 3, 2, 2, -1, 0, 1'b0);
        idleCycle();

        applyStimulus(16'b10, 2, 3, 0);
        runBurst(16'b10, 2, 3, 0, -1, 0, 1'b0);
        idleCycle();

        applyStimulus(16'hFFFF, 0, 3, 1);
        runBurst(16'hFFFF, 0, 3, 1, -1, 0, 1'b0);
        idleCycle();

        applyStimulus(16'hA5C3, 20, 1, 0);
        runBurst(16'hA5C3, 20, 1, 0, -1, 0, 1'b0);
        idleCycle();

        applyStimulus(16'b1101, 4, 0, 0);
        runBurst(16'b1101, 4, 0, 0, 2, 1, 1'b1);

        // start held through the done cycle must wait one more cycle
        applyStimulus(16'b0110, 4, 1, 0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("b2b_reject_valid", 32'(x_valid), 32'd0);
        checkOutput("b2b_reject_done", 32'(done), 32'd0);
        runBurst(16'b0110, 4, 1, 0, -1, 0, 1'b0);
        idleCycle();

        for (int n = 0; n < 20; n++) begin
            p    = W'($urandom);
            l    = $urandom_range(0, 20);
            r    = $urandom_range(0, 4);
            g    = $urandom_range(0, 3);
            eff  = (l > W) ? W : l;
            srep = -1;
            sbit = 0;
            if (r == 0 && eff < 3) r = 1;
            if (eff >= 3 && (r == 0 || $urandom_range(0, 1) == 1)) begin
                srep = $urandom_range(0, (r == 0) ? 3 : r - 1);
                sbit = $urandom_range(0, eff - 3);
            end
            applyStimulus(p, l, r, g);
            runBurst(p, l, r, g, srep, sbit, 1'($urandom_range(0, 1)));
            idleCycle();
        end

        applyStimulus(16'hFFFF, 16, 2, 0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("pre_reset_valid", 32'(x_valid), 32'd1);
        checkOutput("pre_reset_x", 32'(x), 32'd1);
        #1 areset = 1'b1;
        #1;
        checkOutput("async_rst_x", 32'(x), 32'd0);
        checkOutput("async_rst_valid", 32'(x_valid), 32'd0);
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        applyStimulus(16'b101, 3, 1, 0);
        runBurst(16'b101, 3, 1, 0, -1, 0, 1'b0);
        idleCycle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Serial test-pattern transmitter: loads a parallel bit pattern and shifts it out MSB-first, one bit per clock, on a single-bit line `x`. It can repeat the pattern with a programmable idle gap between repetitions. It is the stimulus source for the serial sequence detectors (e.g. the "101" Mealy/Moore FSMs): its `x` connects directly to a detector's `x` input. A start/busy/done handshake lets a controller or bench kick off bursts without hand-timing each bit.

## Interface
- `W`, 16: maximum pattern length in bits.
- `LW`, `$clog2(W+1)`: width of `len`.
- `RW`, 8: width of the repeat count.
- `GW`, 4: width of the inter-pattern gap count.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `areset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a burst; sampled only in IDLE.
- `pattern`  in  W  bits to send; bit `len-1` is sent first, bit 0 last.
- `len`  in  LW  pattern length, 0..W; values above W saturate to W.
- `repeat_n`  in  RW  number of pattern transmissions; 0 means continuous until `stop`.
- `gap`  in  GW  zero-valued idle cycles inserted between repetitions.
- `stop`  in  1  graceful termination request.
- `x`  out  1  serial data; forced to 0 whenever `x_valid` = 0.
- `x_valid`  out  1  high while a pattern bit is on `x`; low during gaps and idle.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  single-cycle pulse when the burst ends.

## Operation
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - `start`=1 and `len`≠0: capture `pattern`, `len`, `repeat_n` and `gap` into internal registers, then go to SHIFT.
  - `start`=1 and `len`=0: go to DONE; no bits are emitted.
- SHIFT:
  - Emits one bit per cycle. The bit counter runs from `len-1` down to 0.
  - At bit 0, the burst is complete if either of these holds: the repetition counter has reached `repeat_n` (with `repeat_n`≠0), or a stop is pending. A complete burst goes to DONE.
  - Otherwise go to GAP if the captured `gap`≠0, else restart SHIFT at bit `len-1` with no bubble.
- GAP:
  - Counts the captured `gap` cycles with `x`=0 and `x_valid`=0, then returns to SHIFT.
  - If stop is pending, go to DONE on the next edge.
- DONE: asserts `done` for one cycle, then returns to IDLE.
- `stop` is latched as "stop pending" whenever it is high in SHIFT or GAP. The current pattern always finishes; patterns are never truncated. `stop` is ignored in IDLE and DONE.
- `start` is ignored in SHIFT, GAP and DONE.
- Changes to inputs after capture have no effect on the burst in progress.
- The repetition counter is RW bits. In continuous mode it does not saturate or wrap in any way that affects behaviour.

## Timing
- All outputs are registered.
- Reset values: `x`=0, `x_valid`=0, `busy`=0, `done`=0; state = IDLE; stop pending cleared.
- Latency: if `start` is accepted at edge N, the first bit appears on `x` (with `x_valid`=1) after edge N+1. `busy` rises after edge N+1.
- One burst lasts `repeat_n·len + (repeat_n−1)·gap` cycles with `x_valid` high or in gap. `done` is high in the cycle after the last bit. `busy` falls in the same cycle that `done` rises.
- Back-to-back: a `start` held high during the `done` cycle is not accepted. The earliest accept is the cycle after `done`.
- `areset` asserted at any point, including mid-SHIFT, forces the reset values immediately without waiting for a clock edge. After release the block sits in IDLE.

## Structure
- Shared package `seq_gen_pkg`: the state enum (IDLE/SHIFT/GAP/DONE) and the default `W`/`RW`/`GW` constants.
- One sub-module: `seq_gen_piso`, a W-bit parallel-in/serial-out shift register with load and shift enables. It exposes its MSB window aligned by `len`.
- The FSM, the bit/gap/repeat counters and stop pending live in the top module.

## Test plan
- Single burst: `pattern`=16'b101, `len`=3, `repeat_n`=1, `gap`=0 → `x`=1,0,1 with `x_valid`=1 on three consecutive cycles, then a `done` pulse. An attached 101 detector fires once.
- Repeat with gap: same pattern, `repeat_n`=2, `gap`=2 → `x_valid` sequence 1,1,1,0,0,1,1,1 and `x` sequence 1,0,1,0,0,1,0,1, then `done`. `busy` is high for 8 cycles.
- Overlap stream: `pattern`=16'b10, `len`=2, `repeat_n`=3, `gap`=0 → `x`=1,0,1,0,1,0 with no bubble. A Mealy 101 detector fires twice.
- Edge inputs:
  - `len`=0 → no `x_valid`, `done` one cycle after `start`.
  - `len`=20 with `W`=16 → exactly 16 bits emitted.
- Continuous plus stop: `repeat_n`=0, `pattern`=4'b1101, `len`=4; pulse `stop` during the 2nd bit of the 3rd repetition → that pattern completes, then `done`. A second `start` while `busy` is ignored.
- Reset mid-shift: assert `areset` between edges during SHIFT → `x`, `x_valid` and `busy` drop to 0 immediately. After release, a new `start` produces a clean burst.
